// File: rtl/mp_addsub_seq.sv
// rtl/mp_addsub_seq.sv - word-serial multi-precision add/subtract sequencer
module mp_addsub_seq #(
    parameter int WORD   = 8,                // adder slice width
    parameter int NWORDS = 4                 // chunks per operation (>= 2)
) (
    input  logic                   clk,          // rising-edge clock
    input  logic                   rst,          // async reset, active high
    input  logic                   start_valid,  // request to start
    output logic                   start_ready,  // high only in IDLE
    input  logic                   sub,          // 0: a+b, 1: a-b (sampled at accept)
    input  logic [WORD*NWORDS-1:0] a,            // operand A (sampled at accept)
    input  logic [WORD*NWORDS-1:0] b,            // operand B (sampled at accept)
    output logic [WORD*NWORDS:0]   result,       // {carry_out, sum}
    output logic                   ovf,          // signed overflow of the N-bit sum
    output logic                   done,         // one-cycle completion pulse
    output logic                   busy          // high in RUN and DONE
);
    localparam int N  = WORD * NWORDS;
    localparam int AW = N - WORD;
    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [N-1:0]    a_sh;
    logic [N-1:0]    b_sh;
    // Holds the lower chunks already produced; the top chunk comes straight
    // from the slice on the final edge.
    logic [AW-1:0]   acc;
    logic            carry;
    logic            sub_q;
    logic [IW-1:0]   idx;
    logic            accept;
    logic            last;
    logic [WORD-1:0] a_i;
    logic [WORD-1:0] b_i;
    logic [WORD:0]   slice;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        accept      = 1'b0;
        last        = 1'b0;
        case (state)
            S_IDLE: begin
                start_ready = 1'b1;
                accept      = start_valid;
                if (start_valid) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                last = (idx == LAST_IDX);
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // One WORD-bit slice; subtraction inverts B here and takes its +1 from
    // the carry preloaded at accept.
    always_comb begin
        a_i   = a_sh[WORD-1:0];
        b_i   = b_sh[WORD-1:0] ^ {WORD{sub_q}};
        slice = {1'b0, a_i} + {1'b0, b_i} + {{WORD{1'b0}}, carry};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            sub_q  <= 1'b0;
            idx    <= '0;
            result <= '0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            sub_q <= sub;
            carry <= sub;
            idx   <= '0;
        end else if (state == S_RUN) begin
            a_sh  <= a_sh >> WORD;
            b_sh  <= b_sh >> WORD;
            // New chunk enters at the top so chunk 0 ends at the LSB.
            acc   <= AW'({slice[WORD-1:0], acc} >> WORD);
            carry <= slice[WORD];
            idx   <= idx + 1'b1;
            if (last) begin
                result <= {slice[WORD], slice[WORD-1:0], acc};
                ovf    <= (a_i[WORD-1] == b_i[WORD-1]) &&
                          (slice[WORD-1] != a_i[WORD-1]);
            end
        end
    end

endmodule
